// File: rtl/mac_accum_relu_if.sv
// mac_accum_relu_if
// Groups the product-input and activation-output handshakes of mac_accum_relu.
//   master : the side that drives products and accepts activations (upstream/bench)
//   slave  : the mac_accum_relu block itself
// Signals:
//   in_valid / in_ready   : product handshake
//   in_mag  [32:0]        : product magnitude
//   in_sign               : product sign, 1 = negative
//   out_valid / out_ready : activation handshake
//   out_data [OUT_W-1:0]  : unsigned activation
//   out_sat               : activation was clamped high
interface mac_accum_relu_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [32:0]      in_mag;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_mag, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_mag, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_accum_relu.sv
// mac_accum_relu
// Takes sign-magnitude products, converts each to two's complement and sums
// N_TERMS of them in a saturating ACC_W-bit accumulator. The final sum is
// arithmetically shifted right by SHIFT, passed through ReLU and clamped to an
// OUT_W-bit unsigned activation, which is held on a valid/ready output.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (drops partial sums and pending output)
//   bus : mac_accum_relu_if.slave (product input, activation output)
// Assumes ACC_W > OUT_W and ACC_W >= 34.
module mac_accum_relu #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  mac_accum_relu_if.slave  bus
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_valid_q, out_valid_d;

  logic                     in_ready_s;
  logic                     accept_s;
  logic                     last_s;
  logic                     out_hs_s;
  logic        [ACC_W-1:0]  mag_ext_s;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W:0]    sum_wide_s;
  logic signed [ACC_W-1:0]  sum_sat_s;
  logic signed [ACC_W-1:0]  r_s;
  logic        [OUT_W-1:0]  clamp_data_s;
  logic                     clamp_sat_s;

  // State register with synchronous reset back to ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave ACCUM on the final accept, leave HOLD on output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s && last_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_hs_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Output logic: in_ready depends only on state and rst, never on in_*.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready_s = !rst;
      ST_HOLD:  in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.in_valid && in_ready_s;
  assign last_s   = (cnt_q == LAST_CNT);
  assign out_hs_s = out_valid_q && bus.out_ready;

  // Product to two's complement, saturating add, rescale, ReLU and clamp.
  always_comb begin
    mag_ext_s  = {{(ACC_W-33){1'b0}}, bus.in_mag};
    // Negating zero yields zero, so negative zero needs no special case.
    if (bus.in_sign) begin
      term_s = {ACC_W{1'b0}} - mag_ext_s;
    end else begin
      term_s = mag_ext_s;
    end
    // One guard bit: overflow iff the two top bits disagree.
    sum_wide_s = {acc_q[ACC_W-1], acc_q} + {term_s[ACC_W-1], term_s};
    if (sum_wide_s[ACC_W] != sum_wide_s[ACC_W-1]) begin
      if (sum_wide_s[ACC_W]) begin
        sum_sat_s = ACC_MIN;
      end else begin
        sum_sat_s = ACC_MAX;
      end
    end else begin
      sum_sat_s = sum_wide_s[ACC_W-1:0];
    end
    r_s = sum_sat_s >>> SHIFT;
    if (r_s[ACC_W-1]) begin
      clamp_data_s = {OUT_W{1'b0}};
      clamp_sat_s  = 1'b0;
    end else if (|r_s[ACC_W-1:OUT_W]) begin
      clamp_data_s = {OUT_W{1'b1}};
      clamp_sat_s  = 1'b1;
    end else begin
      clamp_data_s = r_s[OUT_W-1:0];
      clamp_sat_s  = 1'b0;
    end
  end

  // Datapath next values: accumulate, register the result, clear on output handshake.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (accept_s) begin
      if (last_s) begin
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        out_data_d  = clamp_data_s;
        out_sat_d   = clamp_sat_s;
        out_valid_d = 1'b1;
      end else begin
        acc_d = sum_sat_s;
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers; reset aborts the vector and drops any pending output.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {OUT_W{1'b0}};
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: doc/mac_accum_relu.md
# mac_accum_relu

Downstream consumer of the sign-magnitude MAC stage. Accepts one product per handshake as a 33-bit magnitude plus sign, and converts it to two's complement. Accumulates N_TERMS products into a saturating accumulator, then rescales, applies ReLU and clamps to a 16-bit unsigned activation. That activation is presented on a valid/ready output, ready to drive the next layer's 16-bit MAC operand with sign 0.

## Interface
- N_TERMS, 16, products per output activation (≥1)
- ACC_W, 40, accumulator width in bits, two's complement (≥34)
- SHIFT, 8, fixed-point rescale: arithmetic right shift applied to the final sum (0 ≤ SHIFT < ACC_W)
- OUT_W, 16, output activation width (unsigned)

- clk  input  1  rising-edge clock, same as MAC stage
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  product present
- in_ready  output  1  block can accept a product
- in_mag  input  33  product magnitude (MAC m)
- in_sign  input  1  product sign, 1 = negative (MAC sign)
- out_valid  output  1  activation available
- out_ready  input  1  downstream accepts activation
- out_data  output  OUT_W  activation, unsigned
- out_sat  output  1  out_data was clamped high on this result

## Operation
- States:
  - ACCUM: collecting terms.
  - HOLD: result presented.
- Reset:
  - Enters ACCUM.
  - acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0.
  - in_ready=0 while rst=1.
- in_ready = (state==ACCUM) && !rst.
- Accept = in_valid && in_ready. On each accept:
  - term = in_sign ? -in_mag : +in_mag, sign-extended to ACC_W.
  - Negative zero (mag 0, sign 1) is 0 and still counts as a term.
  - acc_next = acc + term, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. No wrap-around.
  - cnt increments.
- On the accept with cnt==N_TERMS-1, the block registers the result and enters HOLD:
  - r = acc_next >>> SHIFT (arithmetic shift, floor; no rounding).
  - If r<0: out_data=0, out_sat=0 (ReLU).
  - If r>2^OUT_W-1: out_data=all ones, out_sat=1.
  - Otherwise out_data=r[OUT_W-1:0], out_sat=0.
  - acc and cnt are cleared to 0 in the same cycle.
- HOLD:
  - out_valid=1; in_ready=0.
  - out_data and out_sat stay stable until out_valid && out_ready.
  - On handshake: out_valid=0 next cycle, state returns to ACCUM.
  - out_data/out_sat retain their last value after handshake (don't-care to consumer).
- in_valid during HOLD is ignored; the upstream stage holds its data per valid/ready rules.
- in_mag/in_sign are sampled only on accept.
- rst in any state aborts the vector: partial sums are discarded and any pending output is dropped.

## Timing
- Output latency: the registered result appears with out_valid=1 one cycle after the final accept.
- Accept rate: one product per cycle in ACCUM.
- Minimum period: N_TERMS+1 cycles per activation, when out_ready is held high.
- The first accept is possible on the first cycle with rst=0.
- Simultaneous events:
  - The output handshake and a new input never coincide (in_ready=0 in HOLD).
  - rst overrides everything.
- Registers: state, cnt (clog2(N_TERMS) bits, min 1), acc, out_data, out_sat, out_valid.
  - in_ready is combinational from state and rst only.
  - No combinational path from in_* to out_*.

## Test plan
Benches use N_TERMS=4, SHIFT=8, OUT_W=16, ACC_W=40.
- Basic: four products mag 256 sign 0, in_valid back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept, out_data=4, out_sat=0; the next vector can be accepted 2 cycles later.
- Signed/ReLU/negative zero: +1000, (3000, sign 1), +500, (0, sign 1) -> sum -1500 -> out_data=0, out_sat=0.
- Truncation: +511, 0, 0, 0 -> out_data=1; then (1, sign 1), 0, 0, 0 -> out_data=0.
- Saturation: four products mag 33'h1_FFFF_FFFF sign 0 -> out_data=16'hFFFF, out_sat=1. A forced accumulator near 2^39-1 plus a positive term clamps and does not wrap to negative.
- Backpressure: hold out_ready=0 for 5 cycles after the result.
  - out_valid stays 1, out_data stays stable, in_ready stays 0.
  - in_valid pulses in this window are not counted.
  - After the handshake, the next vector of +256 ×4 gives 4.
- Reset mid-vector: accept 2 products of +25600, assert rst for 1 cycle, then 4 × +256 -> out_data=4. A reset asserted during HOLD clears out_valid the next cycle.
